// File: rtl/bike_pkg.sv
// Shared constants, rng_start encodings, sampler state type and FIFO word packing
// for the h0 random-index front end.
package bike_pkg;
  localparam int R         = 10163;
  localparam int H_DAT_W   = 14;
  localparam int RAW_W     = 32;
  localparam int RNG_DAT_W = 64;
  localparam int SLOT_W    = 16;
  localparam int LO_OFS    = 0;
  localparam int HI_OFS    = 16;

  localparam logic [H_DAT_W-1:0] R_V = R[H_DAT_W-1:0];

  localparam logic [1:0] RNG_IDLE    = 2'd0;
  localparam logic [1:0] RNG_RUN     = 2'd1;
  localparam logic [1:0] RNG_RESTART = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_PUSH
  } smp_state_e;

  function automatic logic [RNG_DAT_W-1:0] pack_pair(input logic [H_DAT_W-1:0] lo,
                                                     input logic [H_DAT_W-1:0] hi);
    logic [RNG_DAT_W-1:0] w;
    w = '0;
    w[LO_OFS +: H_DAT_W] = lo;
    w[HI_OFS +: H_DAT_W] = hi;
    return w;
  endfunction
endpackage

// File: rtl/rng_slot_chk.sv
// Per-slot candidate check: mask to H_DAT_W, accept if < r, optionally reject a
// duplicate of the pair's first candidate (RNG_PAIR_DUP_FILTER_EN).
module rng_slot_chk
  import bike_pkg::*;
(
  input  logic [SLOT_W-1:0]  slot_in,
  input  logic [H_DAT_W-1:0] ref_val,
  input  logic               ref_vld,
  output logic [H_DAT_W-1:0] cand,
  output logic               accept
);
`ifdef RNG_PAIR_DUP_FILTER_EN
  localparam logic DUP_EN = 1'b1;
`else
  localparam logic DUP_EN = 1'b0;
`endif

  logic unused_hi;

  assign unused_hi = ^slot_in[SLOT_W-1:H_DAT_W];
  assign cand      = slot_in[H_DAT_W-1:0];
  assign accept    = (cand < R_V) & ~(DUP_EN & ref_vld & (cand == ref_val));
endmodule

// File: rtl/rng_rej_sampler.sv
// Rejection sampler: splits raw words into two slots, keeps candidates < r and
// packs accepted ones in pairs into RNG FIFO words. Option: RNG_PAIR_DUP_FILTER_EN.
module rng_rej_sampler
  import bike_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           rng_start,
  input  logic                 raw_valid,
  output logic                 raw_ready,
  input  logic [RAW_W-1:0]     raw_din,
  input  logic                 fifo_full,
  output logic                 fifo_wr,
  output logic [RNG_DAT_W-1:0] fifo_dout,
  output logic [15:0]          rej_cnt
);
  smp_state_e           state_q, state_d;
  logic [H_DAT_W-1:0]   c1_q, c1_d;
  logic                 c1_vld_q, c1_vld_d;
  logic [RNG_DAT_W-1:0] dout_q, dout_d;
  logic [15:0]          rej_q, rej_d;

  logic [H_DAT_W-1:0] cand0, cand1, ref1;
  logic               acc0, acc1, ref1_vld, xfer;
  logic [1:0]         rej_inc;
  logic [16:0]        rej_sum;

  assign raw_ready = (state_q == ST_FILL) & (rng_start == RNG_RUN);
  assign xfer      = raw_valid & raw_ready;
  assign fifo_wr   = (state_q == ST_PUSH) & ~fifo_full;
  assign fifo_dout = dout_q;
  assign rej_cnt   = rej_q;

  // Slot1 pairs with the held c1 only if slot0 did not already complete that pair;
  // with nothing held it pairs with an accepted slot0.
  always_comb begin
    ref1     = c1_q;
    ref1_vld = 1'b0;
    if (c1_vld_q) begin
      ref1_vld = ~acc0;
    end else begin
      ref1     = cand0;
      ref1_vld = acc0;
    end
  end

  rng_slot_chk u_slot0 (
    .slot_in (raw_din[SLOT_W-1:0]),
    .ref_val (c1_q),
    .ref_vld (c1_vld_q),
    .cand    (cand0),
    .accept  (acc0)
  );

  rng_slot_chk u_slot1 (
    .slot_in (raw_din[2*SLOT_W-1:SLOT_W]),
    .ref_val (ref1),
    .ref_vld (ref1_vld),
    .cand    (cand1),
    .accept  (acc1)
  );

  assign rej_inc = {1'b0, ~acc0} + {1'b0, ~acc1};
  assign rej_sum = {1'b0, rej_q} + {15'd0, rej_inc};

  always_comb begin
    state_d  = state_q;
    c1_d     = c1_q;
    c1_vld_d = c1_vld_q;
    dout_d   = dout_q;
    rej_d    = rej_q;
    if (rng_start == RNG_RESTART) begin
      state_d  = ST_FILL;
      c1_vld_d = 1'b0;
      rej_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: c1_vld_d = 1'b0;
        ST_FILL: begin
          if (rng_start == RNG_IDLE) begin
            state_d  = ST_IDLE;
            c1_vld_d = 1'b0;
          end else if (xfer) begin
            rej_d = rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
            if (c1_vld_q) begin
              if (acc0) begin
                dout_d   = pack_pair(c1_q, cand0);
                state_d  = ST_PUSH;
                c1_d     = cand1;
                c1_vld_d = acc1;
              end else if (acc1) begin
                dout_d   = pack_pair(c1_q, cand1);
                state_d  = ST_PUSH;
                c1_vld_d = 1'b0;
              end
            end else if (acc0 && acc1) begin
              dout_d  = pack_pair(cand0, cand1);
              state_d = ST_PUSH;
            end else if (acc0 || acc1) begin
              c1_d     = acc0 ? cand0 : cand1;
              c1_vld_d = 1'b1;
            end
          end
        end
        ST_PUSH: begin
          if (rng_start == RNG_IDLE) begin
            state_d  = ST_IDLE;
            c1_vld_d = 1'b0;
          end else if (fifo_wr) begin
            state_d = ST_FILL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      c1_q     <= '0;
      c1_vld_q <= 1'b0;
      dout_q   <= '0;
      rej_q    <= '0;
    end else begin
      state_q  <= state_d;
      c1_q     <= c1_d;
      c1_vld_q <= c1_vld_d;
      dout_q   <= dout_d;
      rej_q    <= rej_d;
    end
  end
endmodule
